// File: rtl/pconv_sched_if.sv
`timescale 1ns/1ps
// pconv_sched_if: signal bundle between pconv_sched and its neighbours.
// The neighbours are the layer FSM, the IFM/OFM RAMs and the pointwise PE array.
// master = the sequencer's view; slave = the view of the surrounding logic.
interface pconv_sched_if #(
   parameter int N      = 16,
   parameter int LW     = 2,
   parameter int ADDR_W = 6
);
   logic              start;
   logic [LW-1:0]     bank_in;
   logic              hold;
   logic              busy;
   logic              done;
   logic              err;
   logic              ifm_rd;
   logic [ADDR_W-1:0] ifm_addr;
   logic [N-1:0]      ifm_rdata;
   logic              pe_vld;
   logic [N-1:0]      pe_din;
   logic [LW-1:0]     bank_sel;
   logic              pe_dout_vld;
   logic              ofm_we;
   logic [ADDR_W-1:0] ofm_addr;

   modport master (
      input  start, bank_in, hold, ifm_rdata, pe_dout_vld,
      output busy, done, err, ifm_rd, ifm_addr, pe_vld, pe_din, bank_sel, ofm_we, ofm_addr
   );

   modport slave (
      output start, bank_in, hold, ifm_rdata, pe_dout_vld,
      input  busy, done, err, ifm_rd, ifm_addr, pe_vld, pe_din, bank_sel, ofm_we, ofm_addr
   );
endinterface

// File: rtl/pconv_sched.sv
`timescale 1ns/1ps
// pconv_sched: sequencer for one pointwise-conv layer pass.
// It streams INPUT_SIZE^2 IFM pixels into the PE array, at most one per clock, and pauses
// while hold is high. It holds the weight/bias/shift bank select for the whole pass, writes
// each PE output vector to the OFM, and pulses done at the end of the pass.
// Optional build macro PCONV_SCHED_TIMEOUT_EN adds a drain watchdog. The watchdog sets the
// sticky err flag and forces completion after 255 idle DRAIN clocks.
//
// state | meaning
// IDLE  | waiting for start; bank_sel keeps the last pass's bank
// FEED  | issuing IFM reads (one per clk unless hold); output writes may already occur
// DRAIN | all reads issued; waiting for the remaining PE output vectors
// DONE  | one clock: done=1, busy=1; back to IDLE next clock
module pconv_sched #(
   parameter int N          = 16,
   parameter int INPUT_SIZE = 6,
   parameter int NUM_BANKS  = 4,
   parameter int ADDR_W     = 6
) (
   input logic           clk,
   input logic           rst_n,
   pconv_sched_if.master bus
);
   localparam int TOTAL = INPUT_SIZE * INPUT_SIZE;
   localparam int LW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int CW    = ADDR_W + 1;
   localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] rd_cnt, wr_cnt;
   logic [LW-1:0] bank_q;
   logic          busy_q;
   logic          rd_d;
   logic [N-1:0]  din_q;
   logic [N-1:0]  pe_din_w;
   logic          start_ok, rd_go, wr_go, timeout;

   // Next-state logic plus the per-clock read/write strobes.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               start_ok  = 1'b1;
               state_nxt = FEED;
            end
         end
         FEED: begin
            rd_go = !bus.hold;
            wr_go = bus.pe_dout_vld;
            if (rd_go && rd_cnt == LAST_C) state_nxt = DRAIN;
            // The output count completing during FEED means the datapath misbehaved.
            // The pass still completes.
            if (wr_go && wr_cnt == LAST_C) state_nxt = DONE;
         end
         DRAIN: begin
            wr_go = bus.pe_dout_vld;
            if (wr_go && wr_cnt == LAST_C) state_nxt = DONE;
            else if (timeout)              state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, pass counters, bank latch and busy flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rd_cnt <= '0;
         wr_cnt <= '0;
         bank_q <= '0;
         busy_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            busy_q <= 1'b1;
            bank_q <= bus.bank_in;
            rd_cnt <= '0;
            wr_cnt <= '0;
         end else begin
            if (rd_go) rd_cnt <= rd_cnt + CW'(1);
            if (wr_go) wr_cnt <= wr_cnt + CW'(1);
            if (state == DONE) busy_q <= 1'b0;
         end
      end
   end

   // The feed pipe matches the one-clock RAM read latency. pe_din follows the RAM word while
   // pe_vld is high and otherwise holds the last pixel delivered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_d  <= 1'b0;
         din_q <= '0;
      end else begin
         rd_d  <= rd_go;
         din_q <= pe_din_w;
      end
   end

   assign pe_din_w = rd_d ? bus.ifm_rdata : din_q;

`ifdef PCONV_SCHED_TIMEOUT_EN
   logic [7:0] idle_cnt;
   logic       err_q;

   // The 254th idle count is the point where the 255th idle DRAIN clock would complete.
   assign timeout = (state == DRAIN) && !bus.pe_dout_vld && (idle_cnt == 8'd254);

   // Counts consecutive DRAIN clocks without an output vector; zero outside DRAIN.
   always_ff @(posedge clk) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (state == DRAIN && !bus.pe_dout_vld && state_nxt == DRAIN)
         idle_cnt <= idle_cnt + 8'd1;
      else
         idle_cnt <= '0;
   end

   // Sticky drain-timeout flag, cleared when a new pass is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n)        err_q <= 1'b0;
      else if (start_ok) err_q <= 1'b0;
      else if (timeout)  err_q <= 1'b1;
   end

   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.busy     = busy_q;
   assign bus.done     = (state == DONE);
   assign bus.bank_sel = bank_q;
   assign bus.ifm_rd   = rd_go;
   assign bus.ifm_addr = rd_go ? rd_cnt[ADDR_W-1:0] : '0;
   assign bus.pe_vld   = rd_d;
   assign bus.pe_din   = pe_din_w;
   assign bus.ofm_we   = wr_go;
   assign bus.ofm_addr = wr_go ? wr_cnt[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_pconv_sched.sv
`timescale 1ns/1ps
// tb_pconv_sched: scoreboard bench for pconv_sched.
// The monitor owns the reference model. When it sees a start the model accepts, it queues
// the expected read addresses, pixels and write addresses. It then pops and compares them
// whenever the DUT presents ifm_rd, pe_vld or ofm_we.
module tb_pconv_sched;
   localparam int N          = 16;
   localparam int INPUT_SIZE = 6;
   localparam int NUM_BANKS  = 4;
   localparam int ADDR_W     = 6;
   localparam int LW         = 2;
   localparam int TOTAL      = INPUT_SIZE * INPUT_SIZE;
`ifdef PCONV_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   drop_tail = 1'b0;

   pconv_sched_if #(.N(N), .LW(LW), .ADDR_W(ADDR_W)) bus ();

   pconv_sched #(.N(N), .INPUT_SIZE(INPUT_SIZE), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // IFM RAM: registered read, data one clock after the strobe.
   logic [N-1:0] ram [2**ADDR_W];
   logic [N-1:0] ram_q = '0;
   always @(posedge clk) if (bus.ifm_rd) ram_q <= ram[bus.ifm_addr];
   assign bus.ifm_rdata = ram_q;

   // PE array: pe_vld delayed 3 clocks; optionally swallows the last 3 vectors of a pass.
   logic [2:0] pe_pipe = '0;
   int         pe_cnt  = 0;
   always @(posedge clk) begin
      pe_pipe <= {pe_pipe[1:0], bus.pe_vld};
      if (!bus.busy)       pe_cnt <= 0;
      else if (pe_pipe[2]) pe_cnt <= pe_cnt + 1;
   end
   assign bus.pe_dout_vld = pe_pipe[2] && !(drop_tail && pe_cnt >= TOTAL - 3);

   // Scoreboard and reference model (written only by the monitor).
   int           n_pass  = 0;
   int           n_total = 0;
   int           exp_rd[$];
   logic [N-1:0] exp_pe[$];
   int           exp_wr[$];
   bit           pass_open    = 1'b0;
   bit           pass_drop    = 1'b0;
   bit           prev_rd      = 1'b0;
   bit           err_exp      = 1'b0;
   longint       acc_cyc      = -10;
   longint       exp_done_cyc = -1;
   logic [LW-1:0] exp_bank = '0;
   logic [LW-1:0] acc_bank = '0;
   logic [N-1:0]  last_pe  = '0;

   task automatic chk(input string nm, input longint act, input longint req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
   endtask

   always @(negedge clk) begin
      bit feed;
      if (!rst_n) begin
         exp_rd.delete();
         exp_pe.delete();
         exp_wr.delete();
         pass_open    = 1'b0;
         pass_drop    = 1'b0;
         prev_rd      = 1'b0;
         err_exp      = 1'b0;
         acc_cyc      = -10;
         exp_done_cyc = -1;
         exp_bank     = '0;
         last_pe      = '0;
      end else begin
         if (cyc == acc_cyc + 1) begin
            exp_bank = acc_bank;
            err_exp  = 1'b0;
         end
         if (cyc == exp_done_cyc && pass_drop && TO_EN) err_exp = 1'b1;

         chk("busy", longint'(bus.busy), longint'(pass_open && cyc > acc_cyc));
         chk("done", longint'(bus.done), longint'(cyc == exp_done_cyc));
         chk("err", longint'(bus.err), longint'(err_exp));
         chk("bank_sel", longint'(bus.bank_sel), longint'(exp_bank));

         feed = pass_open && cyc > acc_cyc && exp_rd.size() > 0;
         chk("ifm_rd", longint'(bus.ifm_rd), longint'(feed && !bus.hold));
         if (bus.ifm_rd) begin
            if (exp_rd.size() == 0) chk("ifm_rd_extra", 1, 0);
            else chk("ifm_addr", longint'(bus.ifm_addr), longint'(exp_rd.pop_front()));
         end

         chk("pe_vld", longint'(bus.pe_vld), longint'(prev_rd));
         if (bus.pe_vld) begin
            if (exp_pe.size() == 0) chk("pe_vld_extra", 1, 0);
            else begin
               last_pe = exp_pe.pop_front();
               chk("pe_din", longint'(bus.pe_din), longint'(last_pe));
            end
         end else begin
            chk("pe_din_hold", longint'(bus.pe_din), longint'(last_pe));
         end
         prev_rd = feed && !bus.hold;

         if (bus.ofm_we) begin
            if (exp_wr.size() == 0) chk("ofm_we_extra", 1, 0);
            else begin
               chk("ofm_addr", longint'(bus.ofm_addr), longint'(exp_wr.pop_front()));
               if (exp_wr.size() == 0)
                  exp_done_cyc = !pass_drop ? cyc + 1 : (TO_EN ? cyc + 256 : -1);
            end
         end

         if (pass_open && !(pass_drop && !TO_EN) && cyc - acc_cyc > 600) begin
            chk("watchdog", cyc - acc_cyc, 600);
            pass_open = 1'b0;
         end

         if (bus.start && !pass_open) begin
            pass_open = 1'b1;
            pass_drop = drop_tail;
            acc_cyc   = cyc;
            acc_bank  = bus.bank_in;
            for (int i = 0; i < TOTAL; i++) begin
               exp_rd.push_back(i);
               exp_pe.push_back(ram[i]);
               if (!drop_tail || i < TOTAL - 3) exp_wr.push_back(i);
            end
         end

         if (cyc == exp_done_cyc) begin
            pass_open    = 1'b0;
            exp_done_cyc = -1;
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives start in the current clock, then shapes hold until the model closes the pass.
   // hold_mode: 0 none, 1 clocks 5..9 of the feed, 2 random.
   task automatic run_pass(input logic [LW-1:0] bank, input int hold_mode, input bit restart,
                           input bit rst_mid, input int limit);
      int n;
      bit stop;
      bus.start   = 1'b1;
      bus.bank_in = bank;
      bus.hold    = 1'b0;
      n    = 0;
      stop = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         bus.start   = restart && (n == 10);
         bus.bank_in = (restart && n == 10) ? LW'(1) : bank;
         case (hold_mode)
            1:       bus.hold = (n >= 5 && n <= 9);
            2:       bus.hold = ($urandom_range(0, 3) == 0);
            default: bus.hold = 1'b0;
         endcase
         if (rst_mid && bus.ifm_rd && bus.ifm_addr == ADDR_W'(20)) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            stop  = 1'b1;
         end
      end while (!stop && (pass_open || n < 2) && n < limit);
      bus.hold  = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.bank_in = '0;
      bus.hold    = 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) ram[i] = N'(i);
      idle(3);
      rst_n = 1'b1;
      idle(3);

      run_pass(LW'(3), 0, 1'b0, 1'b0, 200);
      idle(2);
      run_pass(LW'(2), 1, 1'b1, 1'b0, 200);
      idle(3);

      for (int i = 0; i < 2**ADDR_W; i++) ram[i] = N'($urandom);
      run_pass(LW'($urandom_range(0, 3)), 2, 1'b0, 1'b0, 300);
      for (int i = 0; i < 2**ADDR_W; i++) ram[i] = N'($urandom);
      run_pass(LW'($urandom_range(0, 3)), 2, 1'b0, 1'b0, 300);
      idle(2);

      run_pass(LW'(1), 0, 1'b0, 1'b1, 200);
      idle(6);
      run_pass(LW'(2), 0, 1'b0, 1'b0, 200);
      idle(2);

      drop_tail = 1'b1;
      run_pass(LW'(3), 0, 1'b0, 1'b0, 420);
      if (pass_open) begin
         rst_n = 1'b0;
         idle(1);
         rst_n = 1'b1;
      end
      idle(6);
      drop_tail = 1'b0;

      for (int i = 0; i < 2**ADDR_W; i++) ram[i] = N'($urandom);
      run_pass(LW'($urandom_range(0, 3)), 2, 1'b0, 1'b0, 300);
      idle(4);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
